// File: rtl/dds_sweep_ctrl_if.sv
// Sweep configuration channel between the PS register bank and dds_sweep_ctrl.
// Carries cfg_bidir only when DDS_SWEEP_BIDIR_EN is defined.
interface dds_sweep_ctrl_if #(
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_f_start;
    logic [31:0]        cfg_f_step;
    logic [STEP_W-1:0]  cfg_n_steps;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [11:0]        cfg_p_word;
    logic [1:0]         cfg_wave_type;
    logic               cfg_loop;
`ifdef DDS_SWEEP_BIDIR_EN
    logic               cfg_bidir;
`endif

    modport master (
`ifdef DDS_SWEEP_BIDIR_EN
        output cfg_bidir,
`endif
        output cfg_valid, cfg_f_start, cfg_f_step, cfg_n_steps, cfg_dwell,
               cfg_p_word, cfg_wave_type, cfg_loop,
        input  cfg_ready
    );

    modport slave (
`ifdef DDS_SWEEP_BIDIR_EN
        input  cfg_bidir,
`endif
        input  cfg_valid, cfg_f_start, cfg_f_step, cfg_n_steps, cfg_dwell,
               cfg_p_word, cfg_wave_type, cfg_loop,
        output cfg_ready
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS core inputs in the clk_dds domain.
// Optional up/down sweep enabled by defining DDS_SWEEP_BIDIR_EN.
module dds_sweep_ctrl #(
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
) (
    input  logic               clk_dds,
    input  logic               rst,
    dds_sweep_ctrl_if.slave    cfg,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               sweep_done,
    output logic [STEP_W-1:0]  step_idx,
    output logic               dds_en,
    output logic               set_flag,
    output logic [31:0]        f_word,
    output logic [11:0]        p_word,
    output logic [1:0]         wave_type
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]  STEP_ZERO  = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0]  STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_nx_s;

    logic [31:0]        sh_f_start_r, sh_f_step_r;
    logic [STEP_W-1:0]  sh_n_steps_r;
    logic [DWELL_W-1:0] sh_dwell_r;
    logic [11:0]        sh_p_word_r;
    logic [1:0]         sh_wave_r;
    logic               sh_loop_r;
    logic               bidir_s;

    logic               cfg_ready_r, busy_r, sweep_done_r, dds_en_r, set_flag_r;
    logic [STEP_W-1:0]  step_idx_r;
    logic [31:0]        f_word_r;
    logic [11:0]        p_word_r;
    logic [1:0]         wave_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic               dir_down_r;

    logic [31:0]        f_word_nx_s;
    logic [STEP_W-1:0]  step_idx_nx_s;
    logic [DWELL_W-1:0] dwell_cnt_nx_s, dwell_ld_s;
    logic               dir_down_nx_s, dds_en_nx_s, sweep_done_nx_s;

`ifdef DDS_SWEEP_BIDIR_EN
    logic               sh_bidir_r;
    assign bidir_s = sh_bidir_r;
`else
    assign bidir_s = 1'b0;
`endif

    // A dwell of zero is held like a dwell of one.
    assign dwell_ld_s = (sh_dwell_r == DWELL_ZERO) ? DWELL_ZERO : (sh_dwell_r - DWELL_ONE);

    assign cfg.cfg_ready = cfg_ready_r;
    assign busy          = busy_r;
    assign sweep_done    = sweep_done_r;
    assign step_idx      = step_idx_r;
    assign dds_en        = dds_en_r;
    assign set_flag      = set_flag_r;
    assign f_word        = f_word_r;
    assign p_word        = p_word_r;
    assign wave_type     = wave_r;

    // Shadow configuration capture on handshake.
    always_ff @(posedge clk_dds or negedge rst) begin
        if (!rst) begin
            sh_f_start_r <= 32'h0000_0000;
            sh_f_step_r  <= 32'h0000_0000;
            sh_n_steps_r <= STEP_ZERO;
            sh_dwell_r   <= DWELL_ZERO;
            sh_p_word_r  <= 12'h000;
            sh_wave_r    <= 2'b00;
            sh_loop_r    <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
            sh_bidir_r   <= 1'b0;
`endif
        end else if (cfg.cfg_valid && cfg_ready_r) begin
            sh_f_start_r <= cfg.cfg_f_start;
            sh_f_step_r  <= cfg.cfg_f_step;
            sh_n_steps_r <= cfg.cfg_n_steps;
            sh_dwell_r   <= cfg.cfg_dwell;
            sh_p_word_r  <= cfg.cfg_p_word;
            sh_wave_r    <= cfg.cfg_wave_type;
            sh_loop_r    <= cfg.cfg_loop;
`ifdef DDS_SWEEP_BIDIR_EN
            sh_bidir_r   <= cfg.cfg_bidir;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk_dds or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and stepping logic; LOAD is also a counting cycle so each
    // frequency stays visible for exactly one dwell.
    always_comb begin
        state_nx_s      = state_r;
        f_word_nx_s     = f_word_r;
        step_idx_nx_s   = step_idx_r;
        dwell_cnt_nx_s  = dwell_cnt_r;
        dir_down_nx_s   = dir_down_r;
        dds_en_nx_s     = dds_en_r;
        sweep_done_nx_s = 1'b0;
        if (stop) begin
            state_nx_s  = ST_IDLE;
            dds_en_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_LOAD, ST_RUN: begin
                    if (dwell_cnt_r != DWELL_ZERO) begin
                        dwell_cnt_nx_s = dwell_cnt_r - DWELL_ONE;
                        state_nx_s     = ST_RUN;
                    end else if (!dir_down_r && (step_idx_r < sh_n_steps_r)) begin
                        f_word_nx_s    = f_word_r + sh_f_step_r;
                        step_idx_nx_s  = step_idx_r + STEP_ONE;
                        dwell_cnt_nx_s = dwell_ld_s;
                        state_nx_s     = ST_RUN;
                    end else if (!dir_down_r && bidir_s && (sh_n_steps_r != STEP_ZERO)) begin
                        dir_down_nx_s  = 1'b1;
                        f_word_nx_s    = f_word_r - sh_f_step_r;
                        step_idx_nx_s  = step_idx_r - STEP_ONE;
                        dwell_cnt_nx_s = dwell_ld_s;
                        state_nx_s     = ST_RUN;
                    end else if (dir_down_r && (step_idx_r != STEP_ZERO)) begin
                        f_word_nx_s    = f_word_r - sh_f_step_r;
                        step_idx_nx_s  = step_idx_r - STEP_ONE;
                        dwell_cnt_nx_s = dwell_ld_s;
                        state_nx_s     = ST_RUN;
                    end else if (sh_loop_r) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s      = ST_IDLE;
                        sweep_done_nx_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output and datapath registers; entering LOAD reloads the sweep.
    always_ff @(posedge clk_dds or negedge rst) begin
        if (!rst) begin
            cfg_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
            dds_en_r     <= 1'b0;
            set_flag_r   <= 1'b0;
            step_idx_r   <= STEP_ZERO;
            f_word_r     <= 32'h0000_0000;
            p_word_r     <= 12'h000;
            wave_r       <= 2'b00;
            dwell_cnt_r  <= DWELL_ZERO;
            dir_down_r   <= 1'b0;
        end else begin
            cfg_ready_r  <= (state_nx_s == ST_IDLE);
            busy_r       <= (state_nx_s != ST_IDLE);
            sweep_done_r <= sweep_done_nx_s;
            if (state_nx_s == ST_LOAD) begin
                f_word_r    <= sh_f_start_r;
                p_word_r    <= sh_p_word_r;
                wave_r      <= sh_wave_r;
                step_idx_r  <= STEP_ZERO;
                dwell_cnt_r <= dwell_ld_s;
                dir_down_r  <= 1'b0;
                dds_en_r    <= 1'b1;
                set_flag_r  <= 1'b1;
            end else begin
                f_word_r    <= f_word_nx_s;
                step_idx_r  <= step_idx_nx_s;
                dwell_cnt_r <= dwell_cnt_nx_s;
                dir_down_r  <= dir_down_nx_s;
                dds_en_r    <= dds_en_nx_s;
                set_flag_r  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl; define DDS_SWEEP_BIDIR_EN to cover the
// up/down sweep as well.
module tb_dds_sweep_ctrl;

    logic        clk_dds = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        busy, sweep_done, dds_en, set_flag;
    logic [15:0] step_idx;
    logic [31:0] f_word;
    logic [11:0] p_word;
    logic [1:0]  wave_type;

    int checks = 0;
    int errors = 0;

    dds_sweep_ctrl_if cfg_if ();

    dds_sweep_ctrl dut (
        .clk_dds    (clk_dds),
        .rst        (rst),
        .cfg        (cfg_if),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .sweep_done (sweep_done),
        .step_idx   (step_idx),
        .dds_en     (dds_en),
        .set_flag   (set_flag),
        .f_word     (f_word),
        .p_word     (p_word),
        .wave_type  (wave_type)
    );

    always #5 clk_dds = ~clk_dds;

    task automatic tick();
        @(posedge clk_dds);
        #1;
    endtask

    task automatic write_cfg(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] ns,
                             input logic [23:0] dw, input logic [11:0] pw, input logic [1:0] wt,
                             input logic lp);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_f_start   = fs;
        cfg_if.cfg_f_step    = fst;
        cfg_if.cfg_n_steps   = ns;
        cfg_if.cfg_dwell     = dw;
        cfg_if.cfg_p_word    = pw;
        cfg_if.cfg_wave_type = wt;
        cfg_if.cfg_loop      = lp;
        tick();
        cfg_if.cfg_valid     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk_dds);
        #1;
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_if.cfg_ready); end
        checks++; if (busy !== 1'b0 || dds_en !== 1'b0 || set_flag !== 1'b0 || sweep_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got busy=%b en=%b sf=%b done=%b exp all 0", busy, dds_en, set_flag, sweep_done); end
        checks++; if (f_word !== 32'h0 || p_word !== 12'h0 || wave_type !== 2'b0 || step_idx !== 16'h0) begin errors++; $display("FAIL reset_data got f=%h p=%h w=%b i=%0d exp 0", f_word, p_word, wave_type, step_idx); end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_up_sweep();
        logic [31:0] fw [4];
        fw = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000};
        write_cfg(32'h0100_0000, 32'h0010_0000, 16'd3, 24'd4, 12'hABC, 2'd2, 1'b0);
        do_start();
        for (int k = 0; k < 16; k++) begin
            checks++; if (f_word !== fw[k/4]) begin errors++; $display("FAIL up_f_word cyc %0d got %h exp %h", k, f_word, fw[k/4]); end
            checks++; if (set_flag !== (k == 0)) begin errors++; $display("FAIL up_set_flag cyc %0d got %b exp %b", k, set_flag, (k == 0)); end
            checks++; if (step_idx !== 16'(k/4)) begin errors++; $display("FAIL up_step_idx cyc %0d got %0d exp %0d", k, step_idx, k/4); end
            checks++; if (dds_en !== 1'b1 || busy !== 1'b1 || sweep_done !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL up_ctrl cyc %0d got en=%b busy=%b done=%b rdy=%b exp 1 1 0 0", k, dds_en, busy, sweep_done, cfg_if.cfg_ready); end
            tick();
        end
        checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL up_done got %b exp 1", sweep_done); end
        checks++; if (f_word !== 32'h0130_0000 || dds_en !== 1'b1) begin errors++; $display("FAIL up_end_hold got f=%h en=%b exp 01300000 1", f_word, dds_en); end
        checks++; if (busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL up_end_idle got busy=%b rdy=%b exp 0 1", busy, cfg_if.cfg_ready); end
        checks++; if (p_word !== 12'hABC || wave_type !== 2'd2) begin errors++; $display("FAIL up_pw_wave got %h %0d exp ABC 2", p_word, wave_type); end
        tick();
        checks++; if (sweep_done !== 1'b0 || dds_en !== 1'b1 || f_word !== 32'h0130_0000) begin errors++; $display("FAIL up_done_pulse got done=%b en=%b f=%h exp 0 1 01300000", sweep_done, dds_en, f_word); end
    endtask

    task automatic test_loop_stop();
        logic [31:0] fw [4];
        fw = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000};
        write_cfg(32'h0100_0000, 32'h0010_0000, 16'd3, 24'd4, 12'hABC, 2'd2, 1'b1);
        do_start();
        for (int k = 0; k < 16; k++) begin
            checks++; if (f_word !== fw[k/4] || set_flag !== (k == 0)) begin errors++; $display("FAIL loop_seq cyc %0d got f=%h sf=%b exp %h %b", k, f_word, set_flag, fw[k/4], (k == 0)); end
            tick();
        end
        checks++; if (f_word !== 32'h0100_0000 || set_flag !== 1'b1 || step_idx !== 16'd0) begin errors++; $display("FAIL loop_restart got f=%h sf=%b i=%0d exp 01000000 1 0", f_word, set_flag, step_idx); end
        checks++; if (sweep_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL loop_no_done got done=%b busy=%b exp 0 1", sweep_done, busy); end
        repeat (5) tick();
        checks++; if (f_word !== fw[1]) begin errors++; $display("FAIL loop_pre_stop got %h exp %h", f_word, fw[1]); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (dds_en !== 1'b0 || busy !== 1'b0 || set_flag !== 1'b0 || sweep_done !== 1'b0) begin errors++; $display("FAIL stop_ctrl got en=%b busy=%b sf=%b done=%b exp 0", dds_en, busy, set_flag, sweep_done); end
        checks++; if (f_word !== fw[1] || p_word !== 12'hABC || wave_type !== 2'd2) begin errors++; $display("FAIL stop_hold got f=%h p=%h w=%0d exp %h ABC 2", f_word, p_word, wave_type, fw[1]); end
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_ready got %b exp 1", cfg_if.cfg_ready); end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (sweep_done !== 1'b0 || dds_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_quiet cyc %0d got done=%b en=%b busy=%b exp 0", k, sweep_done, dds_en, busy); end
        end
    endtask

    task automatic test_wrap_dwell0();
        write_cfg(32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 24'd0, 12'h123, 2'd1, 1'b0);
        do_start();
        checks++; if (f_word !== 32'hFFFF_FFF0 || set_flag !== 1'b1 || step_idx !== 16'd0) begin errors++; $display("FAIL wrap_first got f=%h sf=%b i=%0d exp FFFFFFF0 1 0", f_word, set_flag, step_idx); end
        tick();
        checks++; if (f_word !== 32'h0000_0010 || step_idx !== 16'd1 || set_flag !== 1'b0 || sweep_done !== 1'b0) begin errors++; $display("FAIL wrap_second got f=%h i=%0d sf=%b done=%b exp 00000010 1 0 0", f_word, step_idx, set_flag, sweep_done); end
        tick();
        checks++; if (sweep_done !== 1'b1 || f_word !== 32'h0000_0010 || busy !== 1'b0 || dds_en !== 1'b1) begin errors++; $display("FAIL wrap_done got done=%b f=%h busy=%b en=%b exp 1 00000010 0 1", sweep_done, f_word, busy, dds_en); end
        checks++; if (p_word !== 12'h123 || wave_type !== 2'd1) begin errors++; $display("FAIL wrap_pw_wave got %h %0d exp 123 1", p_word, wave_type); end
        tick();
    endtask

    task automatic test_start_stop_cfg();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++; if (busy !== 1'b0 || dds_en !== 1'b0 || set_flag !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL startstop got busy=%b en=%b sf=%b rdy=%b exp 0 0 0 1", busy, dds_en, set_flag, cfg_if.cfg_ready); end
        checks++; if (f_word !== 32'h0000_0010) begin errors++; $display("FAIL startstop_hold got %h exp 00000010", f_word); end
        tick();
        checks++; if (busy !== 1'b0 || set_flag !== 1'b0) begin errors++; $display("FAIL startstop_idle got busy=%b sf=%b exp 0 0", busy, set_flag); end
        write_cfg(32'h0100_0000, 32'h0010_0000, 16'd3, 24'd4, 12'hABC, 2'd2, 1'b0);
        do_start();
        tick();
        tick();
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL run_ready got %b exp 0", cfg_if.cfg_ready); end
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_f_start   = 32'hDEAD_0000;
        cfg_if.cfg_f_step    = 32'h0000_0001;
        cfg_if.cfg_n_steps   = 16'd0;
        cfg_if.cfg_dwell     = 24'd1;
        cfg_if.cfg_p_word    = 12'h555;
        cfg_if.cfg_wave_type = 2'd3;
        cfg_if.cfg_loop      = 1'b1;
        tick();
        cfg_if.cfg_valid     = 1'b0;
        tick();
        checks++; if (f_word !== 32'h0110_0000 || p_word !== 12'hABC || busy !== 1'b1) begin errors++; $display("FAIL run_cfg_ignored got f=%h p=%h busy=%b exp 01100000 ABC 1", f_word, p_word, busy); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_start();
        checks++; if (f_word !== 32'h0100_0000 || p_word !== 12'hABC || wave_type !== 2'd2 || set_flag !== 1'b1) begin errors++; $display("FAIL shadow_kept got f=%h p=%h w=%0d sf=%b exp 01000000 ABC 2 1", f_word, p_word, wave_type, set_flag); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        write_cfg(32'h0100_0000, 32'h0010_0000, 16'd3, 24'd4, 12'hABC, 2'd2, 1'b0);
        do_start();
        repeat (6) tick();
        #3 rst = 1'b0;
        #1;
        checks++; if (f_word !== 32'h0 || p_word !== 12'h0 || wave_type !== 2'b0 || step_idx !== 16'h0) begin errors++; $display("FAIL arst_data got f=%h p=%h w=%b i=%0d exp 0", f_word, p_word, wave_type, step_idx); end
        checks++; if (dds_en !== 1'b0 || busy !== 1'b0 || set_flag !== 1'b0 || sweep_done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_ctrl got en=%b busy=%b sf=%b done=%b rdy=%b exp 0 0 0 0 1", dds_en, busy, set_flag, sweep_done, cfg_if.cfg_ready); end
        #2 rst = 1'b1;
        tick();
        test_up_sweep();
    endtask

`ifdef DDS_SWEEP_BIDIR_EN
    task automatic test_bidir();
        logic [15:0] idx [10];
        logic [31:0] exp_f;
        idx = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0};
        cfg_if.cfg_bidir = 1'b1;
        write_cfg(32'h0000_1000, 32'h0000_0100, 16'd2, 24'd2, 12'h000, 2'd0, 1'b0);
        cfg_if.cfg_bidir = 1'b0;
        do_start();
        for (int k = 0; k < 10; k++) begin
            exp_f = 32'h0000_1000 + 32'(idx[k]) * 32'h0000_0100;
            checks++; if (step_idx !== idx[k] || f_word !== exp_f || sweep_done !== 1'b0) begin errors++; $display("FAIL bidir_seq cyc %0d got i=%0d f=%h done=%b exp %0d %h 0", k, step_idx, f_word, sweep_done, idx[k], exp_f); end
            tick();
        end
        checks++; if (sweep_done !== 1'b1 || step_idx !== 16'd0 || f_word !== 32'h0000_1000) begin errors++; $display("FAIL bidir_done got done=%b i=%0d f=%h exp 1 0 00001000", sweep_done, step_idx, f_word); end
        tick();
    endtask
`endif

    initial begin
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_f_start   = 32'h0;
        cfg_if.cfg_f_step    = 32'h0;
        cfg_if.cfg_n_steps   = 16'h0;
        cfg_if.cfg_dwell     = 24'h0;
        cfg_if.cfg_p_word    = 12'h0;
        cfg_if.cfg_wave_type = 2'b0;
        cfg_if.cfg_loop      = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
        cfg_if.cfg_bidir     = 1'b0;
`endif
        test_reset();
        test_up_sweep();
        test_loop_stop();
        test_wrap_dwell0();
        test_start_stop_cfg();
        test_async_reset();
`ifdef DDS_SWEEP_BIDIR_EN
        test_bidir();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
